rgb2yuv_stream_ctrl: RTL
========================

# rgb2yuv_stream_ctrl

Streaming controller that sequences the team's RGB→YUV converter arithmetic over an AXI4-Stream video path. It accepts 24-bit RGB pixels with SOF/EOL sideband and emits either YUV 4:4:4 or YUYV 4:2:2 beats with full backpressure support. Configuration is applied only at frame boundaries. The block sits between the camera capture interface and the VDMA write channel inside the image data converter IP.

## Interface
- DATA_WIDTH, 8, component width; only 8 is supported.
- FRAME_CNT_WIDTH, 16, width of the frame counter.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cfg_mode  in  1  0 = YUYV 4:2:2, 1 = YUV 4:4:4; sampled only at SOF acceptance.
- s_axis_tdata  in  24  pixel: R[23:16], G[15:8], B[7:0].
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat accepted when high together with tvalid.
- s_axis_tuser  in  1  start of frame, on the first pixel of a frame.
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  24  4:4:4 mode: {V,U,Y}. 4:2:2 mode: {8'h00, C, Y}.
- m_axis_tvalid / m_axis_tready  out / in  1  output handshake.
- m_axis_tuser / m_axis_tlast  out  1  sideband, passed through aligned with the beat.
- sts_active_mode  out  1  mode latched at the last SOF.
- sts_odd_line  out  1  sticky: a line ended on an even-phase pixel in 4:2:2 mode.
- sts_frame_cnt  out  FRAME_CNT_WIDTH  count of accepted SOF beats; wraps.

## Operation
- Conversion uses per-pixel arithmetic on unsigned 8-bit values. `>>8` and `>>1` truncate. All results are taken mod 256.
  - Y = (77R>>8) + (148G>>8) + (29B>>8)
  - U = 128 + (B>>1) − (43R>>8) − (85G>>8)
  - V = 128 + (R>>1) − (107G>>8) − (21B>>8)
- FSM states:
  - WAIT_SOF (reset state): beats are accepted and discarded. No output, no counting.
  - Accepting tuser=1 in any state:
    - latches cfg_mode into sts_active_mode;
    - increments sts_frame_cnt;
    - processes the beat as a first pixel;
    - moves to EVEN.
  - EVEN: a pixel is emitted and the FSM moves to ODD.
    - 4:2:2: C = U of this pixel; V of this pixel is stored in a v_hold register.
    - 4:4:4: {V,U,Y}; the FSM stays in EVEN.
  - ODD: C = v_hold, Y = current pixel Y; go to EVEN.
  - tlast on any accepted beat forces the next state to EVEN.
  - tlast accepted in EVEN while in 4:2:2 sets sts_odd_line. That beat is still emitted with C = U.
- tuser and tlast may arrive on the same beat. SOF handling applies first, then the EOL rule.
- cfg_mode changes mid-frame have no effect until the next SOF.

## Timing
- Output register plus a 1-entry skid buffer. Latency is 1 cycle from input acceptance to m_axis_tvalid.
- Full throughput is 1 beat/cycle while m_axis_tready is high.
- s_axis_tready is registered and equals !skid_valid. It is independent of m_axis_tready in the same cycle.
- Backpressure rules:
  - When m_axis_tready is low with the output register full, the next accepted beat goes to the skid buffer.
  - s_axis_tready deasserts the following cycle.
  - The skid buffer drains before any new beat is accepted.
- While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata/tuser/tlast hold stable.
- The FSM and v_hold update on input acceptance, not on output.
- Reset values, one cycle after rst is high:
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0, m_axis_tlast = 0;
  - s_axis_tready = 1;
  - skid and v_hold cleared;
  - state = WAIT_SOF;
  - sts_active_mode = 0, sts_odd_line = 0, sts_frame_cnt = 0.
- Reset mid-frame discards all buffered beats without emitting them. Remaining pixels of that frame are dropped until the next SOF.
- sts_frame_cnt wraps from all-ones to 0.

## Test plan
- Black then white, mode 1 (SOF on the first beat) -> beats 0x80_80_00, then 0x81_81_FB. tuser is on beat 0 only. Latency is 1 cycle.
- Mode 0, one line {red 0xFF0000 (SOF), blue 0x0000FF (tlast)} -> 0x00564C (tuser), then 0x00FF1C (tlast). V of red (255) is carried into beat 1.
- Three pixels before the first SOF, then an SOF frame -> the first three are accepted with no output. sts_frame_cnt = 1.
- Mode 0, 3-pixel line ending with tlast -> third beat C = U of pixel 2. sts_odd_line = 1. Next line starts in EVEN.
- m_axis_tready held low 5 cycles during a continuous input stream -> at most 2 beats buffered. s_axis_tready drops after 1 cycle. Output order is preserved with no loss or duplication.
- cfg_mode toggled mid-frame, then rst asserted mid-line -> mode changes only at the next SOF. After rst all outputs are at reset values, and output resumes only after the next tuser.

Source files
------------

// File: rtl/rgb2yuv_stream_ctrl_if.sv
// AXI4-Stream video beat bundle shared by the converter's input and output ports.
interface rgb2yuv_stream_ctrl_if #(
    parameter int unsigned DATA_W = 24
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tuser;
    logic              tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/rgb2yuv_stream_ctrl.sv
// RGB888 -> YUV 4:4:4 / YUYV 4:2:2 stream converter with frame-boundary config,
// output register plus one-entry skid buffer.
module rgb2yuv_stream_ctrl #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_mode,
    rgb2yuv_stream_ctrl_if.slave       s_axis,
    rgb2yuv_stream_ctrl_if.master      m_axis,
    output logic                       sts_active_mode,
    output logic                       sts_odd_line,
    output logic [FRAME_CNT_WIDTH-1:0] sts_frame_cnt
);
    localparam int unsigned CW    = DATA_WIDTH;
    localparam int unsigned PW    = 2 * DATA_WIDTH;
    localparam int unsigned PIX_W = 3 * DATA_WIDTH;

    localparam int unsigned C_YR = 77;
    localparam int unsigned C_YG = 148;
    localparam int unsigned C_YB = 29;
    localparam int unsigned C_UR = 43;
    localparam int unsigned C_UG = 85;
    localparam int unsigned C_VG = 107;
    localparam int unsigned C_VB = 21;

    typedef struct packed {
        logic             user;
        logic             last;
        logic [PIX_W-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        EVEN     = 2'd1,
        ODD      = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] v_hold_q, v_hold_d;
    beat_t         out_q, skid_q, beat_d;
    logic          out_valid_q, skid_valid_q;
    logic          accept, sof, emit, odd_set, mode_eff, even_eff, out_free;
    logic [CW-1:0] r, g, b, y_c, u_c, v_c;

    assign s_axis.tready = ~skid_valid_q;
    assign accept        = s_axis.tvalid & ~skid_valid_q;
    assign sof           = accept & s_axis.tuser;
    assign out_free      = ~out_valid_q | m_axis.tready;

    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tlast  = out_q.last;

    // Colour conversion; every term truncates to CW bits so results wrap mod 256.
    always_comb begin
        r   = s_axis.tdata[3*CW-1:2*CW];
        g   = s_axis.tdata[2*CW-1:CW];
        b   = s_axis.tdata[CW-1:0];
        y_c = CW'((PW'(C_YR) * PW'(r)) >> 8) + CW'((PW'(C_YG) * PW'(g)) >> 8)
            + CW'((PW'(C_YB) * PW'(b)) >> 8);
        u_c = CW'(128) + (b >> 1) - CW'((PW'(C_UR) * PW'(r)) >> 8)
            - CW'((PW'(C_UG) * PW'(g)) >> 8);
        v_c = CW'(128) + (r >> 1) - CW'((PW'(C_VG) * PW'(g)) >> 8)
            - CW'((PW'(C_VB) * PW'(b)) >> 8);
    end

    // Pixel-phase FSM; an SOF beat behaves as the first pixel of an EVEN phase.
    always_comb begin
        state_d  = state_q;
        v_hold_d = v_hold_q;
        emit     = 1'b0;
        odd_set  = 1'b0;
        beat_d   = '0;
        mode_eff = sof ? cfg_mode : sts_active_mode;
        even_eff = sof | (state_q == EVEN);
        if (accept && (sof || state_q != WAIT_SOF)) begin
            emit        = 1'b1;
            beat_d.user = s_axis.tuser;
            beat_d.last = s_axis.tlast;
            if (mode_eff) begin
                beat_d.data = {v_c, u_c, y_c};
                state_d     = EVEN;
            end else if (even_eff) begin
                beat_d.data = {CW'(0), u_c, y_c};
                v_hold_d    = v_c;
                odd_set     = s_axis.tlast;
                state_d     = s_axis.tlast ? EVEN : ODD;
            end else begin
                beat_d.data = {CW'(0), v_hold_q, y_c};
                state_d     = EVEN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_SOF;
            v_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            v_hold_q <= v_hold_d;
        end
    end

    // Status registers: mode and frame count move only on SOF acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sts_active_mode <= 1'b0;
            sts_odd_line    <= 1'b0;
            sts_frame_cnt   <= '0;
        end else begin
            if (sof) begin
                sts_active_mode <= cfg_mode;
                sts_frame_cnt   <= sts_frame_cnt + FRAME_CNT_WIDTH'(1);
            end
            if (odd_set) begin
                sts_odd_line <= 1'b1;
            end
        end
    end

    // Output register with skid; the skid always drains before the next input is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (emit) begin
                out_q       <= beat_d;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (emit) begin
            skid_q       <= beat_d;
            skid_valid_q <= 1'b1;
        end
    end
endmodule
